shift_arbiter: RTL



---
 rtl/shift_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 32-bit shifter among NREQ requesters, with a registered one-entry result stage.
// Optional per-requester grant and stall counters are enabled by defining SHIFT_ARB_STATS_EN.
module shift_arbiter #(
    parameter int NREQ  = 2,
    parameter int AMT_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*32-1:0]    req_src,
    input  logic [NREQ-1:0]       req_dir,
    input  logic [NREQ-1:0]       req_sign,
    input  logic [NREQ*AMT_W-1:0] req_amt,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [31:0]           rsp_result,
    output logic                  busy
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]    stat_grants,
    output logic [15:0]           stat_stall
`endif
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [31:0]       result_q, result_d;

    logic              found;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  nxt_ptr;
    logic [31:0]       win_src;
    logic              win_dir;
    logic              win_sign;
    logic [AMT_W-1:0]  win_amt;
    logic [31:0]       shift_num;
    logic [31:0]       shift_out;
    logic              drain;
    logic              can_grant;
    logic              grant;

    // Shared shifter: left, logical right, or arithmetic right by the zero-extended amount.
    function automatic logic [31:0] shift_op(input logic [31:0] src, input logic dir,
                                             input logic sign, input logic [31:0] num);
        logic signed [31:0] s_src;
        s_src = $signed(src);
        if (dir) begin
            return src << num;
        end else if (sign) begin
            return $unsigned(s_src >>> num);
        end else begin
            return src >> num;
        end
    endfunction

    always_comb begin
        int idx;
        found     = 1'b0;
        grant_idx = '0;
        nxt_ptr   = '0;
        win_src   = '0;
        win_dir   = 1'b0;
        win_sign  = 1'b0;
        win_amt   = '0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = PTR_W'(idx);
                nxt_ptr   = (idx + 1 == NREQ) ? '0 : PTR_W'(idx + 1);
                win_src   = req_src[idx*32 +: 32];
                win_dir   = req_dir[idx];
                win_sign  = req_sign[idx];
                win_amt   = req_amt[idx*AMT_W +: AMT_W];
            end
        end
    end

    assign shift_num = 32'(win_amt);
    assign shift_out = shift_op(win_src, win_dir, win_sign, shift_num);

    always_comb begin
        drain       = (state_q == FULL) && (|(rsp_valid_q & rsp_ready));
        can_grant   = (state_q == EMPTY) || drain;
        grant       = can_grant && found;
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = rsp_valid_q;
        result_d    = result_q;
        req_ready   = '0;
        if (grant) begin
            req_ready[grant_idx]   = 1'b1;
            result_d               = shift_out;
            rsp_valid_d            = '0;
            rsp_valid_d[grant_idx] = 1'b1;
            state_d                = FULL;
            rr_ptr_d               = nxt_ptr;
        end else if (drain) begin
            rsp_valid_d = '0;
            state_d     = EMPTY;
        end
    end

    // Output stage register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            result_q    <= result_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign busy       = (state_q == FULL);

`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] grant_cnt_q [NREQ];
    logic [15:0] grant_cnt_d [NREQ];
    logic [15:0] stall_cnt_q, stall_cnt_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
            if (grant && (int'(grant_idx) == i)) begin
                grant_cnt_d[i] = sat_inc(grant_cnt_q[i]);
            end
        end
        stall_cnt_d = stall_cnt_q;
        if ((|req_valid) && !can_grant) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt_q[i] <= grant_cnt_d[i];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            stat_grants[i*16 +: 16] = grant_cnt_q[i];
        end
    end

    assign stat_stall = stall_cnt_q;
`endif

endmodule
